// File: rtl/mem_arb_pkg.sv
// Shared constants for the fetch/data memory arbiter: response FSM encoding,
// wait-counter width and data width.
package mem_arb_pkg;

    localparam int DATA_W  = 32;
    localparam int WAIT_W  = 4;
    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RESP_I = 2'd1;
    localparam state_t ST_RESP_D = 2'd2;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of fetch port, data port and shared single-port memory signals.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int AW = 7
);

    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              stall_if;

    logic              dm_req;
    logic              dm_we;
    logic [AW-1:0]     dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, stall_if,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, stall_if,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// Counts consecutive cycles the fetch port is refused; saturates at MAX_WAIT
// and flags when fetch must be given priority.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              gnt,
    output logic [WAIT_W-1:0] cnt,
    output logic              at_limit
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/mem_arb.sv
// Two-port arbiter (fetch, data) in front of one shared single-port memory,
// with starvation protection for fetch and a one-cycle read response path.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 7
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  bus
);

    logic              req_i;
    logic              req_d;
    logic              gnt_i;
    logic              gnt_d;
    logic              at_limit;
    logic [WAIT_W-1:0] wait_cnt;
    logic [AW-1:0]     addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    state_t            state;
    state_t            state_nxt;

    // Requests are masked by reset so every output is quiet while rst is high.
    assign req_i = bus.if_req & ~rst;
    assign req_d = bus.dm_req & ~rst;

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .req      (req_i),
        .gnt      (gnt_i),
        .cnt      (wait_cnt),
        .at_limit (at_limit)
    );

    assign gnt_i = req_i & (~req_d | at_limit);
    assign gnt_d = req_d & ~gnt_i;

    // NOTE: defaults first so no path through the block can infer a latch.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        if (gnt_i) begin
            addr_mux = bus.if_addr;
        end else if (gnt_d) begin
            addr_mux  = bus.dm_addr;
            wdata_mux = bus.dm_wdata;
        end
    end

    assign bus.if_gnt    = gnt_i;
    assign bus.dm_gnt    = gnt_d;
    assign bus.stall_if  = req_i & ~gnt_i;
    assign bus.mem_en    = gnt_i | gnt_d;
    assign bus.mem_we    = gnt_d & bus.dm_we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

    always_comb begin
        state_nxt = ST_IDLE;
        if (gnt_i) begin
            state_nxt = ST_RESP_I;
        end else if (gnt_d && !bus.dm_we) begin
            state_nxt = ST_RESP_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign bus.if_rvalid = (state == ST_RESP_I);
    assign bus.dm_rvalid = (state == ST_RESP_D);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;

endmodule
